// File: rtl/arm_pkg.sv
// Shared definitions for the SRAM data-memory controller: FSM encoding,
// default timing and the data-segment base address.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_e;

  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam logic [31:0] DATA_BASE_DEF   = 32'd1024;

  // Byte address to 17-bit SRAM word index; addresses below the base wrap.
  function automatic logic [16:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return off[18:2];
  endfunction

endpackage

// File: rtl/mem_sram_ctrl.sv
// 32-bit load/store front end for a 16-bit SRAM: each access is split into a
// low and a high half-word phase, each lasting WAIT_CYCLES clocks.
module mem_sram_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_res,
  input  logic [31:0] val_Rm,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  sram_state_e state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [16:0] wa_q;
  logic [15:0] data_hi_q;
  logic [31:0] rdata_q;
  logic [17:0] addr_q;
  logic [15:0] dq_out_q;
  logic        dq_oe_q;
  logic        we_n_q;

  logic        req;
  logic [16:0] wa_d;

  assign req  = mem_r_en | mem_w_en;
  assign wa_d = word_index(alu_res, DATA_BASE);

  // SRAM pins are registered so each phase drives them for its full duration;
  // a write wins when both enables are high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      wa_q      <= '0;
      data_hi_q <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      dq_out_q  <= '0;
      dq_oe_q   <= 1'b0;
      we_n_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            state_q   <= LO;
            cnt_q     <= WAIT_LAST;
            wr_q      <= mem_w_en;
            wa_q      <= wa_d;
            data_hi_q <= val_Rm[31:16];
            addr_q    <= {wa_d, 1'b0};
            dq_oe_q   <= mem_w_en;
            we_n_q    <= ~mem_w_en;
            if (mem_w_en) dq_out_q <= val_Rm[15:0];
          end
        end
        LO: begin
          if (cnt_q == 4'd0) begin
            state_q <= HI;
            cnt_q   <= WAIT_LAST;
            addr_q  <= {wa_q, 1'b1};
            if (wr_q) dq_out_q <= data_hi_q;
            else      rdata_q[15:0] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HI: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            if (!wr_q) rdata_q[31:16] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready       = (state_q == DONE) | ((state_q == IDLE) & ~req);
  assign rdata       = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl at default parameters with a small
// 16-entry SRAM model indexed by the low address bits.
module tb_mem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_Rm;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] mem [16];
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .alu_res    (alu_res),
    .val_Rm     (val_Rm),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  assign sram_dq_in = mem[sram_addr[3:0]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 16; k++) mem[k] <= 16'h1000 + 16'(k);
      mem_ready <= 1'b1;
    end else if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[3:0]] <= sram_dq_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called one step after a rising edge in an IDLE cycle; returns in the DONE cycle.
  task automatic run_access(input string tag, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [17:0] lo, input logic [31:0] exp_rdata);
    mem_r_en = r;
    mem_w_en = w;
    alu_res  = a;
    val_Rm   = d;
    #1;
    chk({tag, "_req_ready"}, 32'(ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk({tag, "_busy_ready"}, 32'(ready), 32'd0);
      chk({tag, "_addr"}, 32'(sram_addr), (i < 2) ? 32'(lo) : 32'(lo + 18'd1));
      chk({tag, "_we_n"}, 32'(sram_we_n), 32'(!w));
      chk({tag, "_oe"}, 32'(sram_dq_oe), 32'(w));
      if (w) chk({tag, "_dq_out"}, 32'(sram_dq_out), (i < 2) ? 32'(d[15:0]) : 32'(d[31:16]));
    end
    cyc();
    chk({tag, "_done_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done_we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, "_done_oe"}, 32'(sram_dq_oe), 32'd0);
    chk({tag, "_done_addr"}, 32'(sram_addr), 32'(lo + 18'd1));
    chk({tag, "_rdata"}, rdata, exp_rdata);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    alu_res  = '0;
    val_Rm   = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_we_n", 32'(sram_we_n), 32'd1);
    chk("idle_oe", 32'(sram_dq_oe), 32'd0);
    chk("idle_rdata", rdata, 32'd0);

    run_access("st1024", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0);
    chk("st1024_mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("st1024_mem1", 32'(mem[1]), 32'h0000DEAD);
    cyc();
    run_access("ld1024", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF);
    cyc();

    run_access("st1028", 1'b0, 1'b1, 32'd1028, 32'h12345678, 18'd2, 32'hDEADBEEF);
    cyc();
    run_access("ld1028", 1'b1, 1'b0, 32'd1028, 32'h0, 18'd2, 32'h12345678);
    chk("st1028_mem2", 32'(mem[2]), 32'h00005678);
    chk("st1028_mem3", 32'(mem[3]), 32'h00001234);
    cyc();

    run_access("both", 1'b1, 1'b1, 32'd1036, 32'h0BADC0DE, 18'd6, 32'h12345678);
    chk("both_mem6", 32'(mem[6]), 32'h0000C0DE);
    chk("both_mem7", 32'(mem[7]), 32'h00000BAD);
    cyc();

    run_access("wrap", 1'b1, 1'b0, 32'd1020, 32'h0, 18'h3FFFE, 32'h100F100E);
    cyc();

    mem_w_en = 1'b1;
    alu_res  = 32'd1032;
    val_Rm   = 32'hCAFEF00D;
    repeat (3) cyc();
    chk("abort_hi_we_n", 32'(sram_we_n), 32'd0);
    chk("abort_hi_addr", 32'(sram_addr), 32'd5);
    rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_addr", 32'(sram_addr), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_ready_req", 32'(ready), 32'd0);
    mem_w_en = 1'b0;
    #1;
    chk("abort_ready_idle", 32'(ready), 32'd1);
    repeat (2) cyc();
    chk("abort_mem4", 32'(mem[4]), 32'h0000F00D);
    chk("abort_mem5", 32'(mem[5]), 32'h00001005);
    rst = 1'b1;
    cyc();
    chk("post_ready", 32'(ready), 32'd1);
    chk("post_we_n", 32'(sram_we_n), 32'd1);
    chk("post_mem5", 32'(mem[5]), 32'h00001005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: cycles per 16-bit SRAM half-access; legal range 1..15.
REQ-002 Parameter DATA_BASE, default 1024: byte address mapped to SRAM word 0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mem_r_en  in  1  load request from the EXE/MEM register; held stable while ready=0.
REQ-006 mem_w_en  in  1  store request; held stable while ready=0.
REQ-007 alu_res  in  32  byte address of the access.
REQ-008 val_Rm  in  32  store data.
REQ-009 rdata  out  32  last loaded word.
REQ-010 ready  out  1  access complete or idle; the pipeline freezes on ~ready.
REQ-011 sram_addr  out  18  SRAM half-word address.
REQ-012 sram_dq_out  out  16  write data to the SRAM data bus.
REQ-013 sram_dq_oe  out  1  tri-state enable for sram_dq_out (top level builds the inout).
REQ-014 sram_dq_in  in  16  read data from the SRAM data bus.
REQ-015 sram_we_n  out  1  active-low SRAM write enable.

Function
REQ-016 req = mem_r_en | mem_w_en; when both are high the access SHALL be a write.
REQ-017 Word index SHALL be wa = (alu_res - DATA_BASE) >> 2, truncated to 17 bits; low half address SHALL be {wa,0}; high half address SHALL be {wa,1}.
REQ-018 FSM states SHALL be IDLE, LO, HI, DONE.
REQ-019 In IDLE with req=1 the FSM SHALL go to LO, latch the direction, wa and val_Rm, and load the wait counter.
REQ-020 LO and HI SHALL each last exactly WAIT_CYCLES cycles; LO SHALL be followed by HI, and HI by DONE.
REQ-021 DONE SHALL last one cycle and then return to IDLE; a request present in the following IDLE cycle SHALL start a new access (back-to-back).
REQ-022 ready SHALL equal (state==DONE) | (state==IDLE & ~req), combinationally.
REQ-023 Latency from the request cycle to ready=1 SHALL be 2*WAIT_CYCLES+1 cycles (5 at the default).
REQ-024 During a write, LO SHALL drive sram_dq_out = data[15:0] and HI SHALL drive data[31:16]; sram_dq_oe and sram_we_n=0 SHALL hold for the whole phase.
REQ-025 During a read, sram_dq_oe=0 and sram_we_n=1; sram_dq_in SHALL be captured on the last cycle of LO into rdata[15:0] and on the last cycle of HI into rdata[31:16].
REQ-026 rdata SHALL change only through read captures; writes and idle cycles SHALL leave it unchanged.
REQ-027 In IDLE and DONE: sram_we_n=1, sram_dq_oe=0, sram_addr holds its last value.
REQ-028 Addresses below DATA_BASE SHALL wrap modulo 2^17 words; no error is flagged.

Reset
REQ-029 On rst low, immediately and regardless of state: state=IDLE, wait counter=0, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
REQ-030 A reset in the middle of an access SHALL abort it with no further SRAM write cycle; after reset ready SHALL follow REQ-022.

Structure
REQ-031 Shared package arm_pkg SHALL hold the FSM state encoding, the WAIT_CYCLES default and the DATA_BASE constant.
REQ-032 No sub-module is required; the wait counter SHALL be inline, 4 bits wide.

Verification
REQ-033 Idle after reset, req=0 -> ready=1, sram_we_n=1, sram_dq_oe=0, rdata=0.
REQ-034 Store 0xDEADBEEF to 1024 -> SRAM addr 0 gets 0xBEEF and addr 1 gets 0xDEAD; ready=0 for 4 cycles, then 1 for 1 cycle.
REQ-035 Load from 1024 with a memory model -> rdata=0xDEADBEEF in the DONE cycle; sram_we_n stays 1 throughout.
REQ-036 Store 0x12345678 to 1028, then a load from 1028 in the next IDLE -> SRAM addrs 2 and 3 are used and rdata=0x12345678.
REQ-037 mem_r_en=mem_w_en=1 -> a write is performed; rdata is unchanged.
REQ-038 rst asserted in the HI phase of a store -> we_n=1 immediately, state=IDLE, high half not written, rdata=0.
